mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter S, default 32, memory word width in bits.
REQ-002 Parameter L, default 256, memory depth in words; AW = $clog2(L).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  CPU access request; sampled only when ready=1.
REQ-006 we  input  1  1=store, 0=load.
REQ-007 size  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-008 uns  input  1  load zero-extend when 1, sign-extend when 0; ignored for word and store.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  S  store data, right-aligned for byte/half.
REQ-011 ready  output  1  block idle and able to accept req.
REQ-012 done  output  1  one-cycle pulse marking completion of an accepted access.
REQ-013 err  output  1  valid with done; 1 = access rejected.
REQ-014 rdata  output  S  load result, registered, valid from done onward.
REQ-015 mem_a  output  AW  word index to data memory.
REQ-016 mem_din  output  S  write data to data memory.
REQ-017 mem_mread  output  1  read strobe to data memory.
REQ-018 mem_mwrite  output  1  write enable; memory writes on posedge when 1.
REQ-019 mem_dout  input  S  combinational read data for mem_a, same cycle.

Function
REQ-020 FSM states: IDLE, ACCESS, WRITE, FIN; ready=1 only in IDLE.
REQ-021 IDLE: req=1 captures we, size, uns, addr, wdata into registers and moves to ACCESS (legal) or FIN with err (illegal); req=0 stays IDLE.
REQ-022 Illegal: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:AW+2] nonzero.
REQ-023 Illegal access: no mem_mread/mem_mwrite assertion at any cycle, rdata unchanged, done=err=1 one cycle after accept.
REQ-024 mem_a = captured addr[AW+1:2] in ACCESS and WRITE; 0 in IDLE/FIN.
REQ-025 Byte lanes little-endian: byte k = bits [8k+7:8k], half h = bits [16h+15:16h].
REQ-026 ACCESS, load: mem_mread=1; rdata <= extracted lane (sign- or zero-extended to S per uns); next FIN.
REQ-027 ACCESS, word store: mem_mwrite=1, mem_din=captured wdata; next FIN.
REQ-028 ACCESS, byte/half store: mem_mread=1, mem_mwrite=0; merged word (mem_dout with addressed lane replaced by wdata low bits) registered; next WRITE.
REQ-029 WRITE: mem_mwrite=1, mem_din=merged word; next FIN.
REQ-030 FIN: done=1 for exactly this cycle, err=0 for legal accesses; next IDLE.
REQ-031 Latency from accept edge to done: load/word store 2 cycles, byte/half store 3 cycles, illegal 1 cycle.
REQ-032 Back-to-back: req held high is accepted again in the IDLE cycle after FIN; throughput one access per 3 (4 for sub-word store) cycles.
REQ-033 req while ready=0 is ignored, not queued.
REQ-034 mem_mwrite asserted at most one cycle per access; never in IDLE or FIN.
REQ-035 mem_din = 0 whenever mem_mwrite=0.

Reset
REQ-036 rst_n=0 forces immediately: state IDLE, ready=1, done=0, err=0, rdata=0, mem_mread=0, mem_mwrite=0, mem_a=0, captured registers 0.
REQ-037 Reset asserted mid-access aborts it: no subsequent memory write, no done pulse for the aborted access.
REQ-038 First req sampled on the first posedge with rst_n=1.

Verification
REQ-039 Word 5 = 0x8899AABB; load byte addr 0x17, uns=0 -> done 2 cycles after accept, rdata=0xFFFFFF88; repeat uns=1 -> 0x00000088.
REQ-040 Word 5 = 0x8899AABB; store half 0x00001234 at 0x16 -> one mread cycle, then one mwrite with mem_a=5, mem_din=0x1234AABB; done 3 cycles after accept.
REQ-041 Load half at 0x15 -> done=err=1 one cycle after accept, no mread/mwrite, rdata unchanged; same for size=11 and addr=0x400 (L=256).
REQ-042 Store word 0xDEADBEEF at 0x08 then load word 0x08 back-to-back (req held) -> mwrite mem_a=2, then rdata=0xDEADBEEF, two done pulses.
REQ-043 Sub-word store 0xAB at 0x03, rst_n low during ACCESS -> mem_mwrite never asserted, word 0 unchanged, ready=1 during reset, no done.
REQ-044 req pulsed while busy (ACCESS) -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit between a CPU request port and a single-port word memory.
// Sub-word stores use a read-modify-write; misaligned or out-of-range accesses are rejected.
module mem_lsu #(
  parameter int S  = 32,
  parameter int L  = 256,
  localparam int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [31:0]   addr,
  input  logic [S-1:0]  wdata,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [S-1:0]  rdata,
  output logic [AW-1:0] mem_a,
  output logic [S-1:0]  mem_din,
  output logic          mem_mread,
  output logic          mem_mwrite,
  input  logic [S-1:0]  mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    FIN    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [S-1:0]  wdata_q, wdata_d;
  logic [S-1:0]  merged_q, merged_d;
  logic [S-1:0]  rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [4:0]    lane_sh_s;
  logic [S-1:0]  shifted_s;
  logic [S-1:0]  load_val_s;
  logic [S-1:0]  lane_mask_s;
  logic [S-1:0]  merge_val_s;

  // Alignment and range legality of a request, evaluated on the raw inputs.
  function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] a);
    logic hi;
    hi = ((a >> (AW + 2)) != 32'd0);
    case (sz)
      2'b00:   is_illegal = hi;
      2'b01:   is_illegal = hi | a[0];
      2'b10:   is_illegal = hi | (a[1:0] != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  assign lane_sh_s = {addr_q[1:0], 3'b000};
  assign shifted_s = mem_dout >> lane_sh_s;
  assign rdata     = rdata_q;

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    load_val_s  = shifted_s;
    lane_mask_s = S'(16'hFFFF);
    case (size_q)
      2'b00: begin
        load_val_s  = {{(S-8){~uns_q & shifted_s[7]}}, shifted_s[7:0]};
        lane_mask_s = S'(16'h00FF);
      end
      2'b01: begin
        load_val_s  = {{(S-16){~uns_q & shifted_s[15]}}, shifted_s[15:0]};
        lane_mask_s = S'(16'hFFFF);
      end
      default: begin
        load_val_s  = shifted_s;
        lane_mask_s = S'(16'hFFFF);
      end
    endcase
    merge_val_s = (mem_dout & ~(lane_mask_s << lane_sh_s)) |
                  ((wdata_q & lane_mask_s) << lane_sh_s);
  end

  // Next-state, register updates and memory-side outputs.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merged_d   = merged_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ready      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    mem_a      = '0;
    mem_din    = '0;
    mem_mread  = 1'b0;
    mem_mwrite = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          if (is_illegal(size, addr)) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        mem_a = addr_q[AW+1:2];
        if (!we_q) begin
          mem_mread = 1'b1;
          rdata_d   = load_val_s;
          state_d   = FIN;
        end else if (size_q == 2'b10) begin
          mem_mwrite = 1'b1;
          mem_din    = wdata_q;
          state_d    = FIN;
        end else begin
          mem_mread = 1'b1;
          merged_d  = merge_val_s;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        mem_a      = addr_q[AW+1:2];
        mem_mwrite = 1'b1;
        mem_din    = merged_q;
        state_d    = FIN;
      end
      FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural word memory and an expected-completion queue.
module tb_mem_lsu;
  localparam int S  = 32;
  localparam int L  = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n, req, we, uns;
  logic [1:0]    size;
  logic [31:0]   addr, wdata;
  logic          ready, done, err, mem_mread, mem_mwrite;
  logic [S-1:0]  rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_a;

  logic [31:0] mem [0:L-1];

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, viol = 0;
  logic [31:0] last_wa = 32'd0, last_wd = 32'd0;
  int r0, w0, d0;

  mem_lsu #(.S(S), .L(L)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_a(mem_a), .mem_din(mem_din), .mem_mread(mem_mread),
    .mem_mwrite(mem_mwrite), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_a];

  always @(posedge clk) if (mem_mwrite) mem[mem_a] <= mem_din;

  // Bus activity counters and protocol invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_mread) rd_cnt++;
    if (mem_mwrite) begin
      wr_cnt++;
      last_wa = {24'd0, mem_a};
      last_wd = mem_din;
    end
    if (done) done_cnt++;
    if (!mem_mwrite && mem_din !== 32'd0) viol++;
    if (ready && (mem_mread || mem_mwrite || mem_a !== 8'd0)) viol++;
    if (done && mem_mwrite) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input logic push, input logic e,
                       input logic [31:0] r, input logic hold);
    chk("ready_before_req", {31'd0, ready}, 32'd1);
    if (push) sb.push_back('{err: e, rdata: r});
    we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start, input int exp_lat);
    int lat;
    exp_t x;
    lat = start;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_sb_entry"}, {31'd0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, "_err"}, {31'd0, err}, {31'd0, x.err});
      chk({tag, "_rdata"}, rdata, x.rdata);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < L; i++) mem[i] = 32'd0;
    mem[5] = 32'h8899AABB;
    mem[0] = 32'h11223344;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mread", {31'd0, mem_mread}, 32'd0);
    chk("rst_mwrite", {31'd0, mem_mwrite}, 32'd0);
    chk("rst_mem_a", {24'd0, mem_a}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // signed and unsigned byte loads of the top byte of word 5
    issue(1'b0, 2'b00, 1'b0, 32'h17, 32'd0, 1'b1, 1'b0, 32'hFFFFFF88, 1'b0);
    wait_done("ldb_s", 1, 2);
    step();
    issue(1'b0, 2'b00, 1'b1, 32'h17, 32'd0, 1'b1, 1'b0, 32'h00000088, 1'b0);
    wait_done("ldb_u", 1, 2);
    step();

    // half store into upper half of word 5 via read-modify-write
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234, 1'b1, 1'b0, 32'h00000088, 1'b0);
    wait_done("sth", 1, 3);
    step();
    chk("sth_mread_cycles", rd_cnt - r0, 32'd1);
    chk("sth_mwrite_cycles", wr_cnt - w0, 32'd1);
    chk("sth_mem_a", last_wa, 32'd5);
    chk("sth_mem_din", last_wd, 32'h1234AABB);
    chk("sth_mem5", mem[5], 32'h1234AABB);

    // illegal accesses: misaligned half, size 11, out of range
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b0, 2'b01, 1'b0, 32'h15, 32'd0, 1'b1, 1'b1, 32'h00000088, 1'b0);
    wait_done("ill_mis", 1, 1);
    step();
    issue(1'b0, 2'b11, 1'b0, 32'h14, 32'd0, 1'b1, 1'b1, 32'h00000088, 1'b0);
    wait_done("ill_size", 1, 1);
    step();
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'd0, 1'b1, 1'b1, 32'h00000088, 1'b0);
    wait_done("ill_range", 1, 1);
    step();
    chk("ill_mread_cycles", rd_cnt - r0, 32'd0);
    chk("ill_mwrite_cycles", wr_cnt - w0, 32'd0);

    // word store then word load with req held high across both
    w0 = wr_cnt; d0 = done_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000088, 1'b1);
    wait_done("b2b_stw", 1, 2);
    we = 1'b0; addr = 32'h08; wdata = 32'd0;
    sb.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
    @(negedge clk);
    chk("b2b_ready_idle", {31'd0, ready}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    wait_done("b2b_ldw", 1, 2);
    step();
    chk("b2b_done_pulses", done_cnt - d0, 32'd2);
    chk("b2b_mwrite_cycles", wr_cnt - w0, 32'd1);
    chk("b2b_mem_a", last_wa, 32'd2);
    chk("b2b_mem2", mem[2], 32'hDEADBEEF);

    // byte store into lane 1, then half loads with both extensions
    issue(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000005A, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    wait_done("stb", 1, 3);
    step();
    chk("stb_mem2", mem[2], 32'hDEAD5AEF);
    issue(1'b0, 2'b01, 1'b0, 32'h0A, 32'd0, 1'b1, 1'b0, 32'hFFFFDEAD, 1'b0);
    wait_done("ldh_s", 1, 2);
    step();
    issue(1'b0, 2'b01, 1'b1, 32'h08, 32'd0, 1'b1, 1'b0, 32'h00005AEF, 1'b0);
    wait_done("ldh_u", 1, 2);
    step();

    // request pulsed while busy must be dropped
    d0 = done_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 1'b1, 1'b0, 32'h1234AABB, 1'b0);
    req = 1'b1; addr = 32'h400;
    @(negedge clk);
    req = 1'b0;
    wait_done("busy_ld", 2, 2);
    repeat (4) @(negedge clk);
    #1;
    chk("busy_done_pulses", done_cnt - d0, 32'd1);
    chk("busy_ready", {31'd0, ready}, 32'd1);

    // reset during the read phase of a byte store aborts it
    w0 = wr_cnt; d0 = done_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h03, 32'h000000AB, 1'b0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_mwrite", {31'd0, mem_mwrite}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("abort_mwrite_cycles", wr_cnt - w0, 32'd0);
    chk("abort_done_pulses", done_cnt - d0, 32'd0);
    chk("abort_mem0", mem[0], 32'h11223344);
    chk("sb_drained", sb.size(), 32'd0);
    chk("protocol_violations", viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
